// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module      : muldiv_ctrl
// Description : RV32M signed front end for an unsigned multi-cycle mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        ex_stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        md_valid,
    output logic        md_mode,
    output logic [31:0] md_in_A,
    output logic [31:0] md_in_B,
    input  logic        md_ready,
    input  logic [63:0] md_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic        neg_q, neg_d;
    logic        mode_q, mode_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;

    logic        w_sgn_a, w_sgn_b;
    logic        w_neg_a, w_neg_b;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_div0, w_ovf;
    logic [31:0] w_special_res;
    logic        w_neg_res;
    logic [63:0] w_prod;
    logic [31:0] w_div_sel, w_div_res, w_post;

    // Operand signedness: MULH/DIV/REM signed on both, MULHSU signed on rs1 only.
    assign w_sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_sgn_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);

    assign w_neg_a = w_sgn_a & rs1_data[31];
    assign w_neg_b = w_sgn_b & rs2_data[31];
    assign w_mag_a = w_neg_a ? (~rs1_data + 32'd1) : rs1_data;
    assign w_mag_b = w_neg_b ? (~rs2_data + 32'd1) : rs2_data;

    assign w_div0 = funct3[2] & (rs2_data == 32'd0);
    assign w_ovf  = funct3[2] & ~funct3[0] &
                    (rs1_data == 32'h8000_0000) & (rs2_data == 32'hFFFF_FFFF);

    assign w_special_res = w_div0 ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                                  : (funct3[1] ? 32'd0    : 32'h8000_0000);

    // A remainder takes the dividend's sign; everything else takes s1^s2.
    assign w_neg_res = (funct3 == 3'b110) ? w_neg_a : (w_neg_a ^ w_neg_b);

    assign w_prod    = neg_q ? (~md_out + 64'd1) : md_out;
    assign w_div_sel = f3_q[1] ? md_out[63:32] : md_out[31:0];
    assign w_div_res = neg_q ? (~w_div_sel + 32'd1) : w_div_sel;
    assign w_post    = f3_q[2] ? w_div_res
                               : ((f3_q == 3'b000) ? w_prod[31:0] : w_prod[63:32]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            f3_q     <= 3'd0;
            neg_q    <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    f3_d   = funct3;
                    neg_d  = w_neg_res;
                    mode_d = funct3[2];
                    a_d    = w_mag_a;
                    b_d    = w_mag_b;
                    if (w_div0 || w_ovf) begin
                        result_d = w_special_res;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (md_ready) begin
                    result_d = w_post;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign ex_stall     = ~rst & (((state_q == ST_IDLE) & ex_valid) |
                                  (state_q == ST_ISSUE) | (state_q == ST_WAIT));
    assign md_valid     = (state_q == ST_ISSUE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;
    assign md_mode      = mode_q;
    assign md_in_A      = a_q;
    assign md_in_B      = b_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl with a behavioural mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        ex_stall;
    logic [31:0] result;
    logic        result_valid;
    logic        md_valid;
    logic        md_mode;
    logic [31:0] md_in_A;
    logic [31:0] md_in_B;
    logic        md_ready = 1'b0;
    logic [63:0] md_out = 64'd0;

    muldiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .funct3       (funct3),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .ex_stall     (ex_stall),
        .result       (result),
        .result_valid (result_valid),
        .md_valid     (md_valid),
        .md_mode      (md_mode),
        .md_in_A      (md_in_A),
        .md_in_B      (md_in_B),
        .md_ready     (md_ready),
        .md_out       (md_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] res;
        bit          special;
        int          t;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        int          t;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];

    int          lat_next  = 1;
    int          ready_cyc = -100;
    bit          unit_busy = 1'b0;
    int          rv_count  = 0;
    logic [31:0] last_result = 32'd0;
    logic [31:0] last_A = 32'd0;
    logic [31:0] last_B = 32'd0;
    logic        last_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got a pulse, required none (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model (RV32M semantics) ----------------
    function automatic bit sgn_a(input logic [2:0] f);
        return (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    endfunction

    function automatic bit sgn_b(input logic [2:0] f);
        return (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
        longint sv;
        sv = longint'($signed(v));
        if (sgn && sv < 0) return 32'(-sv);
        return v;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return ((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        pu  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: return pu[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // ---------------- behavioural unsigned mul/div unit ----------------
    initial begin
        logic [31:0] ua, ub;
        logic        um;
        int          l;
        forever begin
            @(negedge clk);
            if (!rst && md_valid) begin
                unit_busy = 1'b1;
                ua = md_in_A;
                ub = md_in_B;
                um = md_mode;
                last_A = ua;
                last_B = ub;
                last_mode = um;
                l = lat_next;
                repeat (l) @(posedge clk);
                #1;
                if (um) begin
                    if (ub == 32'd0) md_out = {ua, 32'hFFFF_FFFF};
                    else             md_out = {ua % ub, ua / ub};
                end else begin
                    md_out = {32'd0, ua} * {32'd0, ub};
                end
                md_ready  = 1'b1;
                ready_cyc = cyc;
                @(posedge clk);
                #1;
                md_ready  = 1'b0;
                md_out    = {$urandom(), $urandom()};
                unit_busy = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        req_t r;
        exp_t e;
        if (rst) begin
            chk("rst_ex_stall", 64'(ex_stall), 64'd0);
            chk("rst_result_valid", 64'(result_valid), 64'd0);
            chk("rst_md_valid", 64'(md_valid), 64'd0);
            chk("rst_md_mode", 64'(md_mode), 64'd0);
            chk("rst_md_in_A", 64'(md_in_A), 64'd0);
            chk("rst_md_in_B", 64'(md_in_B), 64'd0);
            chk("rst_result", 64'(result), 64'd0);
        end else begin
            if (md_valid) begin
                if (req_q.size() == 0) begin
                    unexpected("md_valid_unexpected");
                end else begin
                    r = req_q.pop_front();
                    chk("md_mode", 64'(md_mode), 64'(r.mode));
                    chk("md_in_A", 64'(md_in_A), 64'(r.a));
                    chk("md_in_B", 64'(md_in_B), 64'(r.b));
                    chk("md_valid_cycle", 64'(cyc), 64'(r.t + 1));
                end
            end
            if (result_valid) begin
                rv_count++;
                if (exp_q.size() == 0) begin
                    unexpected("result_valid_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    last_result = result;
                    chk("result", 64'(result), 64'(e.res));
                    if (e.special) chk("special_latency", 64'(cyc), 64'(e.t + 1));
                    else           chk("ready_to_result", 64'(cyc), 64'(ready_cyc + 1));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int lat);
        exp_t e;
        req_t r;
        lat_next  = lat;
        e.res     = ref_res(f, a, b);
        e.special = is_special(f, a, b);
        e.t       = cyc;
        exp_q.push_back(e);
        if (!e.special) begin
            r.mode = f[2];
            r.a    = mag(a, sgn_a(f));
            r.b    = mag(b, sgn_b(f));
            r.t    = cyc;
            req_q.push_back(r);
        end
        ex_valid = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int lat);
        int sc;
        int t0;
        bit done;
        bit sp;
        sp   = is_special(f, a, b);
        start_op(f, a, b, lat);
        t0   = cyc;
        sc   = 0;
        done = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (ex_stall) begin
                sc++;
            end else begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL op_timeout: ex_stall still 1 after 120 cycles, required 0");
        end else begin
            chk("rv_at_stall_release", 64'(result_valid), 64'd1);
            if (sp) chk("stall_cycles", 64'(sc), 64'd1);
            else    chk("stall_cycles", 64'(sc), 64'(ready_cyc + 1 - t0));
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int rv_before;
        ex_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ex_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 3);
        chk("lit_MUL", 64'(last_result), 64'hFFFF_FFEB);
        chk("lit_MUL_A", 64'(last_A), 64'd7);
        chk("lit_MUL_B", 64'(last_B), 64'hFFFF_FFFD);
        chk("lit_MUL_mode", 64'(last_mode), 64'd0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1);
        chk("lit_MULH", 64'(last_result), 64'h4000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        chk("lit_MULHSU", 64'(last_result), 64'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
        chk("lit_MULHU", 64'(last_result), 64'hFFFF_FFFE);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 2);
        chk("lit_DIV", 64'(last_result), 64'hFFFF_FFFD);
        chk("lit_DIV_A", 64'(last_A), 64'd7);
        chk("lit_DIV_B", 64'(last_B), 64'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 4);
        chk("lit_REM", 64'(last_result), 64'hFFFF_FFFF);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 7);
        chk("lit_DIVU", 64'(last_result), 64'h7FFF_FFFC);
        run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 1);
        chk("lit_REMU", 64'(last_result), 64'h0000_0001);
        run_op(3'd4, 32'd5, 32'd0, 1);
        chk("lit_DIV0", 64'(last_result), 64'hFFFF_FFFF);
        run_op(3'd6, 32'd5, 32'd0, 1);
        chk("lit_REM0", 64'(last_result), 64'h0000_0005);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        chk("lit_DIV_ovf", 64'(last_result), 64'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        chk("lit_REM_ovf", 64'(last_result), 64'h0000_0000);

        // Abort an operation while it waits on the unit; its late md_ready must be dropped.
        rv_before = rv_count;
        start_op(3'd0, 32'd5, 32'd6, 30);
        repeat (5) @(posedge clk);
        #1;
        rst      = 1'b1;
        ex_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!unit_busy) break;
            @(posedge clk);
            #1;
        end
        chk("late_ready_delivered", 64'(unit_busy), 64'd0);
        @(negedge clk);
        chk("idle_after_reset", 64'(ex_stall), 64'd0);
        chk("no_rv_for_aborted", 64'(rv_count), 64'(rv_before));
        @(posedge clk);
        #1;
        run_op(3'd3, 32'd3, 32'd5, 4);
        chk("lit_MULHU_after_rst", 64'(last_result), 64'd0);

        for (int n = 0; n < 200; n++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(1, 40));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("pending_results", 64'(exp_q.size()), 64'd0);
        chk("pending_requests", 64'(req_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Signed-operation front end for the unsigned multi-cycle multiply/divide unit in the EX stage of the RV32M datapath. It decodes `funct3` of an M-extension instruction and converts `rs1`/`rs2` to unsigned magnitudes. It issues one `multu`/`divu` request downstream, waits for its `ready`, then restores signs and selects the high or low word. It stalls the pipeline for the whole operation and resolves divide-by-zero and signed overflow locally, without using the unit.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  M-extension instruction present in EX; held stable while `ex_stall`=1.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  32  operand A.
- `rs2_data`  in  32  operand B.
- `ex_stall`  out  1  pipeline hold request.
- `result`  out  32  rd write data; valid only with `result_valid`.
- `result_valid`  out  1  one-cycle pulse.
- `md_valid`  out  1  one-cycle request to the mul/div unit.
- `md_mode`  out  1  0 = multu, 1 = divu.
- `md_in_A`  out  32  unsigned magnitude A (multiplicand / dividend).
- `md_in_B`  out  32  unsigned magnitude B (multiplier / divisor).
- `md_ready`  in  1  one-cycle completion pulse from the unit.
- `md_out`  in  64  unit result: multu = 64-bit product; divu = {remainder[63:32], quotient[31:0]}.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: when `ex_valid`=1, latch `funct3`, the operand signs, the magnitudes and the special-case flags.
  - If a special case applies, load the result and go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: drive `md_valid`=1 for exactly this cycle, with registered `md_mode`/`md_in_A`/`md_in_B`, then go to WAIT.
- WAIT: `md_valid`=0. On `md_ready`=1, capture `md_out`, post-process, register `result`, go to DONE.
- DONE: `result_valid`=1, then go to IDLE.
- `ex_stall` = (state==IDLE && `ex_valid`) || state==ISSUE || state==WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Sign flags: s1 = `rs1_data`[31], s2 = `rs2_data`[31]. Magnitude = value if the operand is treated unsigned or non-negative, otherwise its two's complement. 0x80000000 maps to 0x80000000.
- Signedness per op:
  - MUL, MULHU, DIVU, REMU: both operands unsigned, no correction.
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
- Multiply post-processing:
  - neg = s1^s2 (MULH) or s1 (MULHSU).
  - P = neg ? (~md_out+1) : md_out, as a 64-bit two's complement.
  - MUL returns P[31:0]; MULH/MULHSU/MULHU return P[63:32].
- Divide post-processing:
  - DIV: quotient negated if s1^s2.
  - REM: remainder negated if s1.
  - DIVU/REMU: raw quotient/remainder.
- Special cases, always resolved locally with no request issued:
  - `rs2_data`==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `rs1_data`.
  - DIV/REM with `rs1_data`==0x80000000 and `rs2_data`==0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
- `md_ready` outside WAIT is ignored. `ex_valid` in ISSUE, WAIT or DONE is ignored; operands are already latched.

## Timing
- Reset values: state IDLE; `result`=0; `result_valid`=0; `md_valid`=0; `md_mode`=0; `md_in_A`=0; `md_in_B`=0.
- `ex_stall` reset value: combinational; 0 while `rst`=1.
- Normal op:
  - Accept at cycle T.
  - `md_valid` high at T+1.
  - `md_ready` seen at cycle R ≥ T+2.
  - `result_valid` high at R+1.
  - Total stall: R+1−T cycles.
- Special case: accept at T, `result_valid` at T+1, 1 stall cycle, `md_valid` never asserted.
- Back-to-back: a new `ex_valid` is accepted in the IDLE cycle directly after DONE. Minimum spacing between `result_valid` pulses is 2 cycles for special cases.
- Reset mid-operation, in any state: immediately IDLE with all outputs at reset values.
  - No `result_valid` is produced for the aborted op.
  - A late `md_ready` after reset is ignored.
- `md_ready` in the same cycle as the WAIT entry does not occur: the unit needs at least one cycle.

## Test plan
The bench models the mul/div unit behaviourally, with programmable latency (1 to 40 cycles).
- Multiply, low word: MUL 0x00000007 × 0xFFFFFFFD -> `result`=0xFFFFFFEB; `md_in_A`=7, `md_in_B`=0xFFFFFFFD, `md_mode`=0.
- Multiply, high words:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- Divide, signed and unsigned:
  - DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; `md_in_A`=7, `md_in_B`=2.
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 0x00000001.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 0x00000005.
  - `result_valid` one cycle after accept; `md_valid` stays 0; `ex_stall` high for exactly 1 cycle.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; no request issued.
- Reset in WAIT: assert `rst` during WAIT, then pulse `md_ready` after release.
  - No `result_valid`; state IDLE.
  - A following MULHU 3×5 completes with `result`=0 and `result_valid` exactly one cycle after its `md_ready`.
